mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// RV64 load/store unit front end: one access at a time, IDLE -> REQ -> WAIT -> DONE.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of being truncated.
module mem_access_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_ready,
  output logic            o_stall,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [7:0]      o_mem_be,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_done,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [2:0]      off_q, off_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic            done_q, done_d;
  logic            misal_q, misal_d;
  logic [2:0]      off_a;

  // Lane offset rounded down to the natural alignment of the access size.
  function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    align_off = off;
      2'd1:    align_off = {off[2:1], 1'b0};
      2'd2:    align_off = {off[2], 2'b00};
      default: align_off = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] be_base(input logic [1:0] size);
    case (size)
      2'd0:    be_base = 8'h01;
      2'd1:    be_base = 8'h03;
      2'd2:    be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction
`endif

  function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [2:0] off,
                                                  input logic [XLEN-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[2:1], 4'b0000} +: 16];
    w = d[{off[2], 5'b00000} +: 32];
    case (f3)
      3'b000:  extend_load = XLEN'(signed'(b));
      3'b001:  extend_load = XLEN'(signed'(h));
      3'b010:  extend_load = XLEN'(signed'(w));
      3'b011:  extend_load = d;
      3'b100:  extend_load = XLEN'(b);
      3'b101:  extend_load = XLEN'(h);
      3'b110:  extend_load = XLEN'(w);
      default: extend_load = '0;
    endcase
  endfunction

  assign off_a = align_off(i_funct3[1:0], i_addr[2:0]);

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    misal_d     = misal_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          is_store_d  = i_is_store;
          funct3_d    = i_funct3;
          off_d       = off_a;
          mem_addr_d  = {i_addr[XLEN-1:3], 3'b000};
          mem_wdata_d = i_is_store ? (i_wdata << {off_a, 3'b000}) : '0;
          mem_be_d    = be_base(i_funct3[1:0]) << off_a;
          misal_d     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          if (is_misaligned(i_funct3[1:0], i_addr[2:0])) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            misal_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
            mem_we_d  = i_is_store;
          end
`else
          state_d   = S_REQ;
          mem_req_d = 1'b1;
          mem_we_d  = i_is_store;
`endif
        end
      end
      S_REQ: begin
        if (i_mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (is_store_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          rdata_d = extend_load(funct3_q, off_q, i_mem_rdata);
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        misal_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 8'd0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      misal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      misal_q     <= misal_d;
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_stall      = ((state_q == S_IDLE) && i_valid) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign o_mem_req    = mem_req_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_be     = mem_be_q;
  assign o_done       = done_q;
  assign o_rdata      = rdata_q;
  assign o_misaligned = misal_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed cases plus randomized loads/stores
// against an arithmetic reference model; a responder plays the memory side.
module tb_mem_access_ctrl;

  logic        i_clk, i_rst, i_valid, i_is_store;
  logic [2:0]  i_funct3;
  logic [63:0] i_addr, i_wdata;
  logic        o_ready, o_stall, o_mem_req, o_mem_we;
  logic [63:0] o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_be;
  logic        i_mem_gnt, i_mem_rvalid;
  logic [63:0] i_mem_rdata;
  logic        o_done, o_misaligned;
  logic [63:0] o_rdata;

  mem_access_ctrl #(.XLEN(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_is_store(i_is_store),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_done(o_done), .o_rdata(o_rdata), .o_misaligned(o_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct { logic chk; logic [63:0] rdata; logic mis; } done_exp_t;
  typedef struct { logic [63:0] addr; logic we; logic [7:0] be; logic [63:0] wdata; } req_exp_t;

  done_exp_t done_q[$];
  req_exp_t  req_q[$];
  int vectors = 0;
  int miscompares = 0;

  int          gnt_dly_cur = 0;
  int          rv_dly_cur  = 0;
  logic [63:0] rdata_cur   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain byte arithmetic on the RV64 rules.
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [63:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    return (int'(addr[2:0]) % size_of(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_off(input logic [2:0] f3, input logic [63:0] addr);
    int off = int'(addr[2:0]);
    return off - (off % size_of(f3));
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] rd);
    int sz = size_of(f3);
    logic [63:0] mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    logic [63:0] val;
    if (f3 == 3'b111) return 64'd0;
    val = (rd >> (8 * model_off(f3, addr))) & mask;
    if (!f3[2] && val[8 * sz - 1]) val = val | ~mask;
    return val;
  endfunction

  // Memory responder: grant after gnt_dly_cur waiting cycles, read data after rv_dly_cur more;
  // stray rvalid pulses are thrown in whenever no access is outstanding.
  initial begin
    int gcnt = 0;
    int rcnt = 0;
    bit rv_pending = 0;
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge i_clk);
      i_mem_gnt = 1'b0;
      i_mem_rvalid = 1'b0;
      if (o_mem_req) begin
        if (gcnt == gnt_dly_cur) begin
          i_mem_gnt = 1'b1;
          gcnt = 0;
          rcnt = 0;
          rv_pending = !o_mem_we;
        end else gcnt++;
      end else if (rv_pending) begin
        if (rcnt == rv_dly_cur) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata = rdata_cur;
          rv_pending = 0;
        end else rcnt++;
      end else if ($urandom_range(0, 3) == 0) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: checks every REQ cycle against the pending request and every o_done against the
  // pending completion.
  initial begin
    req_exp_t  r;
    done_exp_t d;
    forever begin
      @(negedge i_clk);
      #2;
      if (!i_rst) begin
        if (o_mem_req) begin
          if (req_q.size() == 0) chk("unexpected_mem_req", 64'd1, 64'd0);
          else begin
            r = req_q[0];
            chk("mem_addr", o_mem_addr, r.addr);
            chk("mem_we", 64'(o_mem_we), 64'(r.we));
            if (r.we) begin
              chk("mem_be", 64'(o_mem_be), 64'(r.be));
              chk("mem_wdata", o_mem_wdata, r.wdata);
            end
            if (i_mem_gnt) void'(req_q.pop_front());
          end
        end
        if (o_done) begin
          if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            d = done_q.pop_front();
            chk("misaligned", 64'(o_misaligned), 64'(d.mis));
            if (d.chk) chk("rdata", o_rdata, d.rdata);
          end
        end
      end
    end
  end

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rd, input int gd, input int rdl,
                       input bit use_exp, input logic [63:0] exp_rd);
    done_exp_t e;
    req_exp_t  r;
    logic      mis;
    int        lat_exp, lat;
    bit        seen;
    mis = model_mis(f3, addr);
    e.mis = mis;
    e.chk = !st || mis;
    e.rdata = mis ? 64'd0 : (use_exp ? exp_rd : model_load(f3, addr, rd));
    done_q.push_back(e);
    if (!mis) begin
      r.addr  = {addr[63:3], 3'b000};
      r.we    = st;
      r.be    = 8'(((1 << size_of(f3)) - 1) << model_off(f3, addr));
      r.wdata = wdata << (8 * model_off(f3, addr));
      req_q.push_back(r);
    end
    gnt_dly_cur = gd;
    rv_dly_cur  = rdl;
    rdata_cur   = rd;
    lat_exp = mis ? 1 : (gd + 2 + (st ? 0 : rdl + 1));
    @(negedge i_clk);
    i_valid = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    #1 chk("idle_ready_stall", 64'({o_ready, o_stall}), 64'd3);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_is_store = $urandom_range(0, 1); i_funct3 = 3'($urandom);
    i_addr = {$urandom, $urandom}; i_wdata = {$urandom, $urandom};
    lat = 0;
    seen = 0;
    while (!seen && lat < 64) begin
      @(negedge i_clk);
      lat++;
      if (o_done) seen = 1;
      else chk("busy_ready_stall", 64'({o_ready, o_stall}), 64'd1);
    end
    chk("done_latency", 64'(lat), 64'(lat_exp));
    if (seen) begin
      chk("done_ready_stall", 64'({o_ready, o_stall}), 64'd0);
      @(negedge i_clk);
      chk("done_pulse_ready", 64'({o_done, o_ready}), 64'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_is_store = 1'b0; i_funct3 = 3'd0; i_addr = '0; i_wdata = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_ctrl", 64'({o_stall, o_mem_req, o_mem_we, o_done, o_misaligned}), 64'd0);
    chk("rst_addr", o_mem_addr, 64'd0);
    chk("rst_rdata", o_rdata, 64'd0);

    do_op(0, 3'b000, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(0, 3'b100, 64'h1003, 0, 64'h0000_0000_8000_0000, 1, 2, 1, 64'h0000_0000_0000_0080);
    do_op(0, 3'b010, 64'h2004, 0, 64'hFFFF_FFF1_0000_0000, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(0, 3'b110, 64'h2004, 0, 64'hFFFF_FFF1_0000_0000, 2, 0, 1, 64'h0000_0000_FFFF_FFF1);
    do_op(1, 3'b001, 64'h3006, 64'h1F, 0, 0, 0, 0, 0);
    do_op(0, 3'b011, 64'h4000, 0, 64'h0123_4567_89AB_CDEF, 3, 0, 1, 64'h0123_4567_89AB_CDEF);
`ifdef MEM_MISALIGN_TRAP_EN
    do_op(0, 3'b010, 64'h2002, 0, 64'h1122_3344_5566_7788, 0, 0, 1, 64'd0);
`else
    do_op(0, 3'b010, 64'h2002, 0, 64'h1122_3344_5566_7788, 0, 0, 1, 64'h0000_0000_5566_7788);
`endif
    do_op(0, 3'b111, 64'h5000, 0, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1, 1, 64'd0);
    do_op(1, 3'b111, 64'h6000, 64'hCAFE_F00D_1234_5678, 0, 1, 0, 0, 0);

    // Reset while waiting for read data; the read data then arrives after reset.
    begin
      req_exp_t r;
      r.addr = 64'h7000; r.we = 1'b0; r.be = 8'hFF; r.wdata = '0;
      req_q.push_back(r);
      gnt_dly_cur = 0; rv_dly_cur = 2; rdata_cur = 64'h5555_AAAA_5555_AAAA;
      @(negedge i_clk);
      i_valid = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b011; i_addr = 64'h7000;
      @(posedge i_clk);
      #1 i_valid = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      chk("wait_rst_ready", 64'({o_ready, o_stall, o_done}), 64'd4);
      chk("wait_rst_rdata", o_rdata, 64'd0);
      repeat (2) begin
        @(negedge i_clk);
        #1 chk("late_rvalid_ignored", 64'({o_ready, o_done, o_mem_req}), 64'd4);
      end
    end

    for (int n = 0; n < 120; n++) begin
      logic st;
      st = 1'($urandom);
      do_op(st, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    repeat (3) @(negedge i_clk);
    chk("done_queue_empty", 64'(done_q.size()), 64'd0);
    chk("req_queue_empty", 64'(req_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
